// File: rtl/param_weight_storage_pkg.sv
// Shared widths and arithmetic helpers for the weight store.
// Holds default widths, saturating subtract and address flattening.
package param_weight_storage_pkg;

    localparam int DEF_DATA_W = 48;
    localparam int DEF_IDX_W  = 32;

    // Working width for the saturating subtract; callers sign-extend
    // into it and truncate the result back to their own width.
    localparam int SAT_W = 128;

    // a - b, clamped to the signed range of a dw-bit word.
    function automatic logic signed [SAT_W-1:0] sat_sub(
        input logic signed [SAT_W-1:0] a,
        input logic signed [SAT_W-1:0] b,
        input int unsigned             dw
    );
        logic signed [SAT_W-1:0] d;
        logic signed [SAT_W-1:0] one;
        logic signed [SAT_W-1:0] mx;
        logic signed [SAT_W-1:0] mn;
        one = SAT_W'(1);
        d   = a - b;
        mx  = (one <<< (dw - 1)) - one;
        mn  = ~mx;
        if (d > mx)
            return mx;
        else if (d < mn)
            return mn;
        else
            return d;
    endfunction

    function automatic int unsigned flat_addr(
        input int unsigned layer,
        input int unsigned row,
        input int unsigned rows
    );
        return layer * rows + row;
    endfunction

endpackage

// File: rtl/matrix_storage_locator.sv
// Sequential (layer,row) read cursor over the weight matrix.
// Ports: clk, clear (to 0,0, wins), advance, layer, row, at_last.
module matrix_storage_locator #(
    parameter int LAYERS = 4,
    parameter int ROWS   = 16,
    localparam int LW    = (LAYERS > 1) ? $clog2(LAYERS) : 1,
    localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic          clk,
    input  logic          clear,
    input  logic          advance,
    output logic [LW-1:0] layer,
    output logic [RW-1:0] row,
    output logic          at_last
);

    logic row_end;
    logic layer_end;

    assign row_end   = (row == RW'(ROWS - 1));
    assign layer_end = (layer == LW'(LAYERS - 1));
    assign at_last   = row_end && layer_end;

    always_ff @(posedge clk) begin
        if (clear) begin
            layer <= '0;
            row   <= '0;
        end else if (advance) begin
            if (row_end) begin
                row   <= '0;
                layer <= layer_end ? '0 : layer + LW'(1);
            end else begin
                row <= row + RW'(1);
            end
        end
    end

endmodule

// File: rtl/param_weight_storage.sv
// Weight store with direct load, 2-stage saturating SGD update and
// sequential read-out. Ports: write/update requests, locator control,
// registered read result (w, indices, valid, last), sticky index_error.
module param_weight_storage
    import param_weight_storage_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int IDX_W    = DEF_IDX_W,
    parameter int LAYERS   = 4,
    parameter int ROWS     = 16,
    parameter int LR_SHIFT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              is_write,
    input  logic [IDX_W-1:0]  write_layer_index,
    input  logic [IDX_W-1:0]  write_row_index,
    input  logic [DATA_W-1:0] write_data,
    input  logic              is_update,
    input  logic [IDX_W-1:0]  update_layer_index,
    input  logic [IDX_W-1:0]  update_row_index,
    input  logic [DATA_W-1:0] dc_dw,
    input  logic              locator_reset,
    input  logic              read_en,
    output logic [DATA_W-1:0] w,
    output logic [IDX_W-1:0]  w_layer_index,
    output logic [IDX_W-1:0]  w_row_index,
    output logic              w_valid,
    output logic              w_last,
    output logic              index_error
);

    localparam int DEPTH = LAYERS * ROWS;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW    = (LAYERS > 1) ? $clog2(LAYERS) : 1;
    localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic [DATA_W-1:0] mem [DEPTH];

    logic wr_ok, up_ok, wr_en, up_en;
    logic [AW-1:0] wr_addr, up_addr, rd_addr;

    // Stage-1 registers of the update pipeline.
    logic                     p_valid;
    logic [AW-1:0]            p_addr;
    logic signed [DATA_W-1:0] p_old;
    logic signed [DATA_W-1:0] p_step;

    logic signed [DATA_W-1:0] commit_val;
    logic                     commit_en;
    logic [DATA_W-1:0]        operand;
    logic [DATA_W-1:0]        rd_val;

    logic [LW-1:0] loc_layer;
    logic [RW-1:0] loc_row;
    logic          loc_last;
    logic          rd_fire;

    assign wr_ok = (write_layer_index < IDX_W'(LAYERS))
                && (write_row_index < IDX_W'(ROWS));
    assign up_ok = (update_layer_index < IDX_W'(LAYERS))
                && (update_row_index < IDX_W'(ROWS));
    assign wr_en = is_write && wr_ok && !reset;
    assign up_en = is_update && up_ok && !reset;

    assign wr_addr = AW'(flat_addr(32'(write_layer_index),
                                   32'(write_row_index), ROWS));
    assign up_addr = AW'(flat_addr(32'(update_layer_index),
                                   32'(update_row_index), ROWS));
    assign rd_addr = AW'(flat_addr(32'(loc_layer), 32'(loc_row), ROWS));

    assign commit_val = DATA_W'(sat_sub(SAT_W'(p_old), SAT_W'(p_step),
                                        DATA_W));
    // A direct load to the committing word supersedes the update.
    assign commit_en = p_valid && !reset
                    && !(wr_en && (wr_addr == p_addr));

    // Operand and read bypass: same-edge load first, then same-edge
    // commit, then the stored word.
    always_comb begin
        operand = mem[up_addr];
        if (wr_en && (wr_addr == up_addr))
            operand = write_data;
        else if (commit_en && (p_addr == up_addr))
            operand = commit_val;
    end

    always_comb begin
        rd_val = mem[rd_addr];
        if (wr_en && (wr_addr == rd_addr))
            rd_val = write_data;
        else if (commit_en && (p_addr == rd_addr))
            rd_val = commit_val;
    end

    assign rd_fire = read_en && !locator_reset;

    matrix_storage_locator #(
        .LAYERS (LAYERS),
        .ROWS   (ROWS)
    ) u_locator (
        .clk     (clk),
        .clear   (reset || locator_reset),
        .advance (rd_fire),
        .layer   (loc_layer),
        .row     (loc_row),
        .at_last (loc_last)
    );

    // Weights survive reset, so the array has no reset branch.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= write_data;
        if (commit_en)
            mem[p_addr] <= commit_val;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            p_valid <= 1'b0;
        end else begin
            p_valid <= up_en;
        end
        if (up_en) begin
            p_addr <= up_addr;
            p_old  <= operand;
            p_step <= $signed(dc_dw) >>> LR_SHIFT;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w             <= '0;
            w_layer_index <= '0;
            w_row_index   <= '0;
            w_valid       <= 1'b0;
            w_last        <= 1'b0;
            index_error   <= 1'b0;
        end else begin
            if (rd_fire) begin
                w             <= rd_val;
                w_layer_index <= IDX_W'(loc_layer);
                w_row_index   <= IDX_W'(loc_row);
                w_valid       <= 1'b1;
                w_last        <= loc_last;
            end else begin
                w_valid <= 1'b0;
                w_last  <= 1'b0;
            end
            if ((is_write && !wr_ok) || (is_update && !up_ok))
                index_error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_param_weight_storage.sv
// Directed bench for param_weight_storage.
// Table of update vectors plus hand sequences for pipeline corners.
module tb_param_weight_storage;

    localparam int DW = 48;
    localparam int IW = 32;
    localparam int NL = 4;
    localparam int NR = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          is_write;
    logic [IW-1:0] write_layer_index;
    logic [IW-1:0] write_row_index;
    logic [DW-1:0] write_data;
    logic          is_update;
    logic [IW-1:0] update_layer_index;
    logic [IW-1:0] update_row_index;
    logic [DW-1:0] dc_dw;
    logic          locator_reset;
    logic          read_en;
    logic [DW-1:0] w;
    logic [IW-1:0] w_layer_index;
    logic [IW-1:0] w_row_index;
    logic          w_valid;
    logic          w_last;
    logic          index_error;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    param_weight_storage #(
        .DATA_W   (DW),
        .IDX_W    (IW),
        .LAYERS   (NL),
        .ROWS     (NR),
        .LR_SHIFT (4)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .is_write           (is_write),
        .write_layer_index  (write_layer_index),
        .write_row_index    (write_row_index),
        .write_data         (write_data),
        .is_update          (is_update),
        .update_layer_index (update_layer_index),
        .update_row_index   (update_row_index),
        .dc_dw              (dc_dw),
        .locator_reset      (locator_reset),
        .read_en            (read_en),
        .w                  (w),
        .w_layer_index      (w_layer_index),
        .w_row_index        (w_row_index),
        .w_valid            (w_valid),
        .w_last             (w_last),
        .index_error        (index_error)
    );

    typedef struct {
        int          layer;
        int          row;
        logic [47:0] init;
        logic [47:0] dc;
        logic [47:0] exp;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int l, input int r, input logic [DW-1:0] v);
        is_write          = 1'b1;
        write_layer_index = l;
        write_row_index   = r;
        write_data        = v;
        tick();
        is_write = 1'b0;
    endtask

    task automatic upd(input int l, input int r, input logic [DW-1:0] d);
        is_update          = 1'b1;
        update_layer_index = l;
        update_row_index   = r;
        dc_dw              = d;
        tick();
        is_update = 1'b0;
    endtask

    task automatic read_at(input int l, input int r,
                           output logic [DW-1:0] v);
        locator_reset = 1'b1;
        tick();
        locator_reset = 1'b0;
        read_en       = 1'b1;
        repeat (l * NR + r) tick();
        tick();
        read_en = 1'b0;
        v = w;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] v;
        int nlast;
        int lastpos;

        vecs[0] = '{0, 0, 48'd100, 48'd32, 48'd98};
        vecs[1] = '{2, 5, 48'h7FFF_FFFF_FFFF, 48'h8000_0000_0000,
                    48'h7FFF_FFFF_FFFF};
        vecs[2] = '{3, 15, 48'h8000_0000_0000, 48'h7FFF_FFFF_FFFF,
                    48'h8000_0000_0000};
        vecs[3] = '{1, 3, 48'd0, 48'hFFFF_FFFF_FFF0, 48'd1};
        vecs[4] = '{3, 0, 48'hFFFF_FFFF_FFFB, 48'd7, 48'hFFFF_FFFF_FFFB};
        vecs[5] = '{2, 7, 48'd1000, 48'd160, 48'd990};

        reset = 1'b1;
        is_write = 1'b0; is_update = 1'b0;
        write_layer_index = '0; write_row_index = '0; write_data = '0;
        update_layer_index = '0; update_row_index = '0; dc_dw = '0;
        locator_reset = 1'b0; read_en = 1'b0;
        tick();
        tick();
        chk("rst_w", 64'(w), 64'd0);
        chk("rst_valid", 64'(w_valid), 64'd0);
        chk("rst_last", 64'(w_last), 64'd0);
        chk("rst_err", 64'(index_error), 64'd0);
        chk("rst_idx", {w_layer_index, w_row_index}, 64'd0);
        reset = 1'b0;
        tick();

        // Direct load then sequential read to (1,2).
        wr(1, 2, 48'd100);
        locator_reset = 1'b1;
        tick();
        locator_reset = 1'b0;
        read_en = 1'b1;
        repeat (NR + 2) tick();
        chk("rd_valid_pre", 64'(w_valid), 64'd1);
        tick();
        read_en = 1'b0;
        chk("rd_w", 64'(w), 64'd100);
        chk("rd_valid", 64'(w_valid), 64'd1);
        chk("rd_idx", {w_layer_index, w_row_index}, {32'd1, 32'd2});
        tick();
        chk("rd_valid_drop", 64'(w_valid), 64'd0);
        chk("rd_w_hold", 64'(w), 64'd100);

        // Table of single updates.
        for (int i = 0; i < 6; i++) begin
            wr(vecs[i].layer, vecs[i].row, vecs[i].init);
            upd(vecs[i].layer, vecs[i].row, vecs[i].dc);
            tick();
            read_at(vecs[i].layer, vecs[i].row, v);
            chk($sformatf("upd_vec%0d", i), 64'(v), 64'(vecs[i].exp));
        end

        // Back-to-back updates on the same word.
        wr(1, 1, 48'd10);
        is_update = 1'b1;
        update_layer_index = 1; update_row_index = 1; dc_dw = 48'd16;
        tick();
        tick();
        is_update = 1'b0;
        tick();
        read_at(1, 1, v);
        chk("b2b_upd", 64'(v), 64'd8);

        // Load in the same cycle as the update request feeds its operand.
        wr(1, 4, 48'd77);
        is_write = 1'b1;
        write_layer_index = 1; write_row_index = 4; write_data = 48'd50;
        is_update = 1'b1;
        update_layer_index = 1; update_row_index = 4; dc_dw = 48'd16;
        tick();
        is_write = 1'b0; is_update = 1'b0;
        tick();
        read_at(1, 4, v);
        chk("fwd_write_op", 64'(v), 64'd49);

        // Load colliding with the commit wins.
        wr(0, 5, 48'd20);
        upd(0, 5, 48'd16);
        wr(0, 5, 48'd300);
        tick();
        read_at(0, 5, v);
        chk("write_beats_commit", 64'(v), 64'd300);

        // Full sweep: w_last only on the final word, then wrap.
        locator_reset = 1'b1;
        tick();
        locator_reset = 1'b0;
        read_en = 1'b1;
        nlast = 0;
        lastpos = -1;
        for (int i = 0; i < NL * NR; i++) begin
            tick();
            if (w_last) begin
                nlast++;
                lastpos = i;
            end
        end
        chk("sweep_nlast", 64'(nlast), 64'd1);
        chk("sweep_lastpos", 64'(lastpos), 64'(NL * NR - 1));
        tick();
        chk("wrap_idx", {w_layer_index, w_row_index}, 64'd0);
        chk("wrap_valid", 64'(w_valid), 64'd1);
        chk("wrap_last", 64'(w_last), 64'd0);
        tick();
        tick();
        locator_reset = 1'b1;
        tick();
        chk("locrst_novalid", 64'(w_valid), 64'd0);
        locator_reset = 1'b0;
        tick();
        read_en = 1'b0;
        chk("locrst_idx", {w_layer_index, w_row_index}, 64'd0);
        chk("locrst_valid", 64'(w_valid), 64'd1);

        // Read sees a load to the same word on the same edge.
        locator_reset = 1'b1;
        tick();
        locator_reset = 1'b0;
        read_en = 1'b1;
        is_write = 1'b1;
        write_layer_index = 0; write_row_index = 0; write_data = 48'd555;
        tick();
        is_write = 1'b0;
        read_en = 1'b0;
        chk("write_first", 64'(w), 64'd555);

        // Out-of-range indices are dropped and flagged.
        wr(1, 0, 48'd4242);
        chk("err_clear", 64'(index_error), 64'd0);
        wr(0, NR, 48'd9999);
        chk("err_set", 64'(index_error), 64'd1);
        upd(NL, 0, 48'd16);
        read_at(1, 0, v);
        chk("err_nowrite", 64'(v), 64'd4242);
        chk("err_sticky", 64'(index_error), 64'd1);

        // Reset between the two update stages blocks the commit.
        wr(2, 2, 48'd600);
        upd(2, 2, 48'd160);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("err_rst", 64'(index_error), 64'd0);
        tick();
        read_at(2, 2, v);
        chk("rst_mid_upd", 64'(v), 64'd600);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
